// File: rtl/input_debouncer_if.sv
// Bundles the raw input and the debounced outputs of input_debouncer.
// The slave modport is the debouncer side; the master modport is the consumer side.
interface input_debouncer_if;
  logic din;
  logic dout;
  logic dout_bar;
  logic rise;
  logic fall;
  logic busy;

  modport master (
    output din,
    input  dout,
    input  dout_bar,
    input  rise,
    input  fall,
    input  busy
  );

  modport slave (
    input  din,
    output dout,
    output dout_bar,
    output rise,
    output fall,
    output busy
  );
endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus a four-state qualification FSM that produces a clean registered level.
// Define DEBOUNCE_EDGE_STROBE_EN to build the rise/fall strobe flops; otherwise both strobes are 0.
module input_debouncer #(
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned CNT_W         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input_debouncer_if.slave  bus
);

  if ((STABLE_CYCLES < 2) || (STABLE_CYCLES > (2 ** CNT_W) - 1)) begin : g_param_check
    $error("input_debouncer: STABLE_CYCLES out of range for CNT_W");
  end

  typedef enum logic [1:0] {
    StIdleLo,
    StChkHi,
    StIdleHi,
    StChkLo
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic             s1_q, s2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    unique case (state_q)
      StIdleLo: begin
        if (s2_q) begin
          state_d = StChkHi;
          cnt_d   = CntOne;
        end else begin
          cnt_d   = '0;
        end
      end
      StChkHi: begin
        if (!s2_q) begin
          // Glitch: drop back without touching dout.
          state_d = StIdleLo;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StIdleHi;
          dout_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CntOne;
        end
      end
      StIdleHi: begin
        if (!s2_q) begin
          state_d = StChkLo;
          cnt_d   = CntOne;
        end else begin
          cnt_d   = '0;
        end
      end
      StChkLo: begin
        if (s2_q) begin
          state_d = StIdleHi;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StIdleLo;
          dout_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdleLo;
        cnt_d   = '0;
        dout_d  = 1'b0;
      end
    endcase
    // Registered busy tracks the next state so it lines up with the state register.
    busy_d = (state_d == StChkHi) || (state_d == StChkLo);
  end

`ifdef DEBOUNCE_EDGE_STROBE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    rise_d = dout_d & ~dout_q;
    fall_d = dout_q & ~dout_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= StIdleLo;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DEBOUNCE_EDGE_STROBE_EN
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`endif
    end else begin
      s1_q    <= bus.din;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
`ifdef DEBOUNCE_EDGE_STROBE_EN
      rise_q  <= rise_d;
      fall_q  <= fall_d;
`endif
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_bar = ~dout_q;
  assign bus.busy     = busy_q;
`ifdef DEBOUNCE_EDGE_STROBE_EN
  assign bus.rise     = rise_q;
  assign bus.fall     = fall_q;
`else
  assign bus.rise     = 1'b0;
  assign bus.fall     = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer: stimulus pushes per-edge expected outputs,
// a negedge monitor pops and compares them.
module tb_input_debouncer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  input_debouncer_if bus ();

  input_debouncer #(
    .STABLE_CYCLES(8),
    .CNT_W        (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef DEBOUNCE_EDGE_STROBE_EN
  localparam bit StrobeEn = 1'b1;
`else
  localparam bit StrobeEn = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [4:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Packed as {dout, dout_bar, rise, fall, busy}.
  function automatic logic [4:0] ev(input logic d, input logic r, input logic f, input logic b);
    return {d, ~d, r & StrobeEn, f & StrobeEn, b};
  endfunction

  function automatic logic [4:0] obs();
    return {bus.dout, bus.dout_bar, bus.rise, bus.fall, bus.busy};
  endfunction

  task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: dout/dout_bar/rise/fall/busy got %b expected %b", nm, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.name, obs(), e.exp);
    end
  end

  task automatic step(input logic d, input string nm, input logic [4:0] e);
    exp_t x;
    bus.din = d;
    @(posedge clk);
    #1;
    x.name = nm;
    x.exp  = e;
    exp_q.push_back(x);
  endtask

  task automatic rise_seq(input string tag, input int n);
    for (int k = 1; k <= n; k++)
      step(1'b1, $sformatf("%s k=%0d", tag, k), ev(k >= 10, k == 10, 1'b0, k >= 3 && k <= 9));
  endtask

  task automatic fall_seq(input string tag, input int n);
    for (int k = 1; k <= n; k++)
      step(1'b0, $sformatf("%s k=%0d", tag, k), ev(k < 10, 1'b0, k == 10, k >= 3 && k <= 9));
  endtask

  initial begin
    logic [4:0] bounce;
    bounce  = 5'b10101;
    rst     = 1'b1;
    bus.din = 1'b1;
    #1;
    check("reset_immediate", obs(), ev(1'b0, 1'b0, 1'b0, 1'b0));
    repeat (5) step(1'b1, "reset_hold", ev(1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    repeat (3) step(1'b0, "idle_lo", ev(1'b0, 1'b0, 1'b0, 1'b0));

    rise_seq("clean_rise", 14);
    fall_seq("clean_fall", 14);

    for (int k = 1; k <= 12; k++)
      step(k <= 4, $sformatf("glitch k=%0d", k), ev(1'b0, 1'b0, 1'b0, k >= 3 && k <= 6));

    // din 1,0,1,0,1 then held; final settle lands on edge 5.
    for (int k = 1; k <= 16; k++)
      step((k <= 5) ? bounce[5-k] : 1'b1, $sformatf("bounce k=%0d", k),
           ev(k >= 14, k == 14, 1'b0, k == 3 || k == 5 || (k >= 7 && k <= 13)));

    fall_seq("fall2", 14);

    for (int k = 1; k <= 6; k++)
      step(1'b1, $sformatf("midq k=%0d", k), ev(1'b0, 1'b0, 1'b0, k >= 3));
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midq_reset_immediate", obs(), ev(1'b0, 1'b0, 1'b0, 1'b0));
    step(1'b1, "midq_reset_hold", ev(1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    rise_seq("rise_after_rst", 12);
    fall_seq("fall3", 14);

    for (int i = 0; i < 5; i++) if (exp_q.size() > 0) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Synchronises and debounces a raw asynchronous input (push-button or external pin) and produces a clean, glitch-free level for the D flip-flop data input `d`. It sits directly upstream of the `dff` stage: `dout` drives `dff.d`, and both blocks share `clk` and `rst`. It also provides single-cycle rise/fall strobes and a busy flag for downstream monitoring.

## Interface
Parameters:
- `STABLE_CYCLES`, default 8: consecutive synchronised samples that must disagree with `dout` before `dout` flips. Legal range is 2 to 2^`CNT_W`-1.
- `CNT_W`, default 4: width of the stability counter.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `din`  input  1  raw asynchronous input. No timing relationship to `clk`.
- `dout`  output  1  debounced level, registered. Feeds `dff.d`.
- `dout_bar`  output  1  always the inverse of `dout`.
- `rise`  output  1  one-cycle strobe on a 0→1 transition of `dout`.
- `fall`  output  1  one-cycle strobe on a 1→0 transition of `dout`.
- `busy`  output  1  high while a candidate transition is being qualified.

## Operation
- Synchroniser: two flops, `s1 <= din` and `s2 <= s1`. Only `s2` feeds the FSM.
- FSM states:
  - IDLE_LO: `dout`=0.
  - CHK_HI: qualifying a rise.
  - IDLE_HI: `dout`=1.
  - CHK_LO: qualifying a fall.
- Transitions from IDLE_LO:
  - `s2`=1 → CHK_HI, `cnt`<=1.
  - Otherwise stay, `cnt`<=0.
- Transitions from CHK_HI:
  - `s2`=0 → IDLE_LO, `cnt`<=0. The glitch is discarded.
  - `s2`=1 and `cnt`==`STABLE_CYCLES`-1 → IDLE_HI, `dout`<=1, `rise`<=1, `cnt`<=0.
  - `s2`=1 otherwise → `cnt`<=`cnt`+1.
- IDLE_HI and CHK_LO mirror IDLE_LO and CHK_HI with polarity inverted. A completed fall sets `fall`<=1.
- `busy` is high exactly in CHK_HI and CHK_LO. It is registered, so it is asserted in the same cycles the state is.
- Counter arithmetic:
  - Unsigned, `CNT_W` bits.
  - It never exceeds `STABLE_CYCLES`-1, so it never wraps.
- `rise` and `fall` are never both high. Each is high for exactly one cycle per `dout` edge.
- Any disagreement sample during CHK restarts qualification from zero. No hysteresis memory is kept.

## Timing
- Reset (asynchronous, immediate, no clock edge needed) takes every output to its reset value:
  - `s1`=`s2`=0, state=IDLE_LO, `cnt`=0.
  - `dout`=0, `dout_bar`=1, `rise`=0, `fall`=0, `busy`=0.
- Reset mid-qualification abandons the qualification.
- After `rst` deasserts, the bench requires at least 2 edges before `s2` reflects `din`.
- Latency from `din` settling stable (meeting setup before edge 1) to `dout` changing:
  - Exactly 2+`STABLE_CYCLES` rising edges, i.e. 10 edges at defaults.
  - `rise`/`fall` assert on that same edge.
  - `busy` asserts at edge 3 and deasserts at edge 2+`STABLE_CYCLES`.
- Glitch rejection:
  - Any `s2` excursion lasting fewer than `STABLE_CYCLES` consecutive cycles produces no `dout` change and no strobe.
  - Such an excursion sets `busy` only.
- `dout` is purely registered. There is no combinational path from `din` to any output.

## Configuration
- Macro `DEBOUNCE_EDGE_STROBE_EN`.
- Defined:
  - `rise` and `fall` are generated as described above.
- Undefined:
  - `rise` and `fall` are tied to constant 0.
  - Their strobe flops are not built.
  - All other behaviour and timing are unchanged.

## Test plan
- Reset: hold `rst`=1 with `din`=1 for 5 cycles → `dout`=0, `dout_bar`=1, `busy`=0, `rise`=0 throughout. This holds immediately on assertion, before any clock edge.
- Clean rise: `rst`=0, then `din` 0→1 and held. Require:
  - `dout`=1 and `rise`=1 on edge 10.
  - `rise`=0 on edge 11.
  - `busy` high over edges 3-9.
  - `fall` never asserted.
- Glitch: with `dout`=0, pulse `din`=1 for 4 cycles then back to 0 → `dout` stays 0, no `rise`, `busy` pulses for 4 cycles then clears.
- Bounce then settle: `din` toggles 1,0,1,0,1 each cycle, then stays 1 → `dout` rises exactly 2+8 edges after the final settle, with a single `rise` strobe.
- Reset mid-qualification: `din`=1 held, assert `rst` at edge 6 (in CHK_HI) for 1 cycle, then release. Require:
  - `dout`=0, `busy`=0, `cnt`=0 immediately on assertion.
  - `dout` rises 10 edges after release.
- Macro off: repeat the clean rise and clean fall with `DEBOUNCE_EDGE_STROBE_EN` undefined → `rise`=`fall`=0 always, and `dout` timing is identical to the macro-on case.
